round_encode_pack: RTL
======================

// Module: round_encode_pack
// PURPOSE
//  Downstream consumer of the polynomial rounding stage in the SNTRUP encapsulation path.
//  Takes P rounded coefficients, one per handshake, each a mod-Q residue of a multiple of 3.
//  Maps each to a digit d=((c+(Q-1)/2) mod Q)/3 in [0,(Q-1)/3], packs digits as fixed 11-bit
//  fields LSB-first into a byte stream, and zero-pads the final byte.
//  Result is the ciphertext rounded-part byte buffer (fixed 11-bit format, not radix Encode).
// PARAMETERS
//  P   761   coefficients per polynomial
//  Q   4591  modulus; (Q-1)/2 must be a multiple of 3; (Q-1)/3 < 2048
//  DW  11    packed digit width, bits
// PORTS
//  clk        in   1   single clock, all logic on rising edge
//  rst        in   1   synchronous, active-high reset
//  start      in   1   1-cycle pulse in IDLE begins one polynomial; ignored otherwise
//  busy       out  1   high from cycle after start until DONE left
//  in_valid   in   1   coefficient offered
//  in_coeff   in   13  rounded coefficient, expected in [0,Q-1] and c mod 3 == 0 after centring
//  in_ready   out  1   high only in ACCEPT; transfer = in_valid & in_ready
//  out_byte   out  8   packed output byte
//  out_valid  out  1   out_byte valid; held with stable data until out_ready
//  out_ready  in   1   downstream accept; transfer = out_valid & out_ready
//  out_last   out  1   high with the final byte of the polynomial
//  err        out  1   sticky: some coefficient out of range or not centred-multiple of 3
// BEHAVIOUR
//  Reset: state IDLE; busy, in_ready, out_valid, out_last, err = 0; out_byte = 0;
//   coeff counter, bit accumulator, fill count cleared. Reset mid-run aborts, no flush.
//  FSM: IDLE -start-> ACCEPT -xfer-> DIV(11 cyc) -> MERGE(1 cyc) -> EMIT
//   EMIT: while fill>=8 offer acc[7:0]; on out xfer shift acc right 8, fill-=8.
//   EMIT with fill<8: if count<P -> ACCEPT; else if fill>0 -> FLUSH; else DONE.
//   FLUSH: offer {zero pad, acc[fill-1:0]} with out_last=1; on xfer -> DONE.
//   DONE: busy=0 one cycle -> IDLE. If P*DW multiple of 8, out_last rides last EMIT byte.
//  Centring: u = c + (Q-1)/2; if u >= Q then u -= Q (14-bit intermediate, no overflow).
//  If c >= Q or u mod 3 != 0: err<=1 (sticky until rst or next start), digit forced to 0,
//   packing continues so byte count stays fixed.
//  DIV: restoring divide u by 3, one quotient bit per cycle MSB-first, 11 iterations;
//   remainder only used for the mod-3 check.
//  MERGE: acc |= digit << fill; fill += 11. Accumulator 18 bits (max fill 7+11).
//  Output bytes: ceil(P*DW/8); P=761 -> 8371 bits -> 1047 bytes, last byte 3 data bits.
//  Backpressure: out_valid high with out_ready low freezes the FSM; out_byte stays stable.
//  in_ready deasserts on the xfer edge; one coefficient in flight at a time.
//  Min cycles per coeff: 1 ACCEPT + 11 DIV + 1 MERGE + bytes emitted (1 or 2).
//  start while busy ignored; in_valid outside ACCEPT ignored (no data loss upstream).
//  Counter of accepted coefficients is 10 bits for P=761; compare against P exactly.
// TESTING
//  1 all c=0 (u=2295, d=765=0x2FD), P=761 -> 1047 bytes; byte0=0xFD, last byte 3 bits, err=0.
//  2 c=Q-2295=2296 (r=-2295) -> d=0; c=2295 -> d=1530; check 11-bit fields in byte stream.
//  3 c=1 (not multiple of 3) at coeff 5 -> err=1 sticky, field 5 = 0, still 1047 bytes.
//  4 c=5000 (>=Q) -> err=1, digit 0; next start clears err.
//  5 out_ready toggled random 50% -> identical byte stream to ready=1 run, no dup/drop.
//  6 rst at coeff 300 -> all outputs 0 next cycle; new start gives clean 1047-byte run.

Source files
------------

// File: rtl/round_encode_pack.sv
// Packs centred, divided-by-3 rounded coefficients as fixed DW-bit fields, LSB-first, into a byte stream.
// One coefficient in flight: 1 accept + DW divide + 1 merge + 1-2 emit cycles; out_valid stalled by out_ready freezes the FSM.
module round_encode_pack #(
  parameter int P  = 761,
  parameter int Q  = 4591,
  parameter int DW = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  input  logic        in_valid,
  input  logic [12:0] in_coeff,
  output logic        in_ready,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        err
);

  localparam int HALF = (Q - 1) / 2;
  localparam int CW   = $clog2(P + 1);
  localparam int AW   = DW + 7;
  localparam int FW   = $clog2(AW + 1);

  typedef enum logic [2:0] {IDLE, ACCEPT, DIV, MERGE, EMIT, FLUSH, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic [AW-1:0]   acc;
  logic [FW-1:0]   fill;
  logic [DW-1:0]   dsh;
  logic [DW-1:0]   quo;
  logic [1:0]      rem;
  logic [3:0]      dcnt;
  logic            bad;

  logic [13:0]     u_sum;
  logic [13:0]     u_cen;
  logic            c_bad;
  logic [2:0]      trial;
  logic [DW-1:0]   digit;
  logic [AW-1:0]   acc_m;
  logic [AW-1:0]   acc_s;
  logic [FW-1:0]   fill_s;

  assign u_sum  = {1'b0, in_coeff} + 14'(HALF);
  assign u_cen  = (u_sum >= 14'(Q)) ? u_sum - 14'(Q) : u_sum;
  assign c_bad  = ({1'b0, in_coeff} >= 14'(Q));
  assign trial  = {rem, dsh[DW-1]};
  // A non-zero remainder means the coefficient was not a centred multiple of 3.
  assign digit  = (bad || rem != 2'd0) ? '0 : quo;
  assign acc_m  = acc | (AW'(digit) << fill);
  assign acc_s  = acc >> 8;
  assign fill_s = fill - FW'(8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_byte  <= '0;
      err       <= 1'b0;
      count     <= '0;
      acc       <= '0;
      fill      <= '0;
      dsh       <= '0;
      quo       <= '0;
      rem       <= '0;
      dcnt      <= '0;
      bad       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCEPT;
            busy     <= 1'b1;
            in_ready <= 1'b1;
            err      <= 1'b0;
            count    <= '0;
            acc      <= '0;
            fill     <= '0;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            count    <= count + CW'(1);
            bad      <= c_bad;
            dsh      <= u_cen[DW-1:0];
            rem      <= 2'(u_cen >> DW);
            quo      <= '0;
            dcnt     <= '0;
            state    <= DIV;
          end
        end
        DIV: begin
          dsh  <= dsh << 1;
          dcnt <= dcnt + 4'd1;
          if (trial >= 3'd3) begin
            rem <= 2'(trial - 3'd3);
            quo <= {quo[DW-2:0], 1'b1};
          end else begin
            rem <= trial[1:0];
            quo <= {quo[DW-2:0], 1'b0};
          end
          if (dcnt == 4'(DW - 1)) state <= MERGE;
        end
        MERGE: begin
          if (bad || rem != 2'd0) err <= 1'b1;
          acc       <= acc_m;
          fill      <= fill + FW'(DW);
          out_valid <= 1'b1;
          out_byte  <= acc_m[7:0];
          out_last  <= 1'b0;
          state     <= EMIT;
        end
        EMIT: begin
          // Merge always leaves at least DW >= 8 bits, so a byte is always on offer here.
          if (out_ready) begin
            acc  <= acc_s;
            fill <= fill_s;
            if (fill_s >= FW'(8)) begin
              out_byte <= acc_s[7:0];
              out_last <= (count == CW'(P)) && (fill_s == FW'(8));
            end else if (count != CW'(P)) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= ACCEPT;
            end else if (fill_s != '0) begin
              out_byte <= acc_s[7:0];
              out_last <= 1'b1;
              state    <= FLUSH;
            end else begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              state     <= DONE;
            end
          end
        end
        FLUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            acc       <= '0;
            fill      <= '0;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
